// File: rtl/command_issue_queue_if.sv
// Handshake and status bundle between the host-side driver and the command issue queue.
// The master drives commands and flush; the slave is the queue itself.
interface command_issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int CMD_W = 12
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CMD_W-1:0] in_cmd;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [CMD_W-1:0] command;
  logic             syscall;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [15:0]      issued_count;

  modport master (
    output in_cmd, in_valid, flush,
    input  in_ready, command, syscall, count, full, empty, issued_count
  );

  modport slave (
    input  in_cmd, in_valid, flush,
    output in_ready, command, syscall, count, full, empty, issued_count
  );
endinterface

// File: rtl/command_issue_queue.sv
// FIFO of controller commands that issues one command at a time with a syscall pulse,
// then holds off for GAP cycles so the controller is back in IDLE before the next pulse.
module command_issue_queue #(
  parameter int DEPTH = 8,
  parameter int CMD_W = 12,
  parameter int GAP   = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  command_issue_queue_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(GAP + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CMD_W-1:0] command_q, command_d;
  logic             syscall_q, syscall_d;
  logic [15:0]      issued_q, issued_d;
  logic             full, push, pop;

  // Flush wins over both push and pop; the pop only happens when IDLE decides to issue.
  assign full = (count_q == CNT_W'(DEPTH));
  assign push = bus.in_valid && !full && !bus.flush;
  assign pop  = (state_q == IDLE) && (count_q != '0) && !bus.flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      command_q <= '0;
      syscall_q <= 1'b0;
      issued_q  <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      command_q <= command_d;
      syscall_q <= syscall_d;
      issued_q  <= issued_d;
    end
  end

  // Hold-off counts down from GAP; leaving HOLD on the edge where it reads 1
  // spaces consecutive pulses GAP+1 cycles apart.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    command_d = command_q;
    syscall_d = 1'b0;
    issued_d  = issued_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          command_d = mem[rd_ptr];
          syscall_d = 1'b1;
          hold_d    = HOLD_W'(GAP);
          issued_d  = issued_q + 16'd1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = !full;
  assign bus.full         = full;
  assign bus.empty        = (count_q == '0);
  assign bus.count        = count_q;
  assign bus.command      = command_q;
  assign bus.syscall      = syscall_q;
  assign bus.issued_count = issued_q;
endmodule

// File: tb/tb_command_issue_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based
// model that only knows "issue allowed once GAP+1 cycles have passed since the last issue".
module tb_command_issue_queue;
  localparam int DEPTH = 8;
  localparam int CMD_W = 12;
  localparam int GAP   = 6;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  command_issue_queue_if #(.DEPTH(DEPTH), .CMD_W(CMD_W)) bus ();

  command_issue_queue #(.DEPTH(DEPTH), .CMD_W(CMD_W), .GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [CMD_W-1:0] mq [$];
  logic [CMD_W-1:0] m_cmd;
  bit               m_sys;
  logic [15:0]      m_issued;
  int               cyc;
  int               last_issue;
  bit               ever_issued;

  task automatic model_reset();
    mq.delete();
    m_cmd = '0;
    m_sys = 1'b0;
    m_issued = '0;
    ever_issued = 1'b0;
  endtask

  // One clock: drive inputs, advance the model across the edge, return #1 after the edge.
  task automatic step(input bit v, input logic [CMD_W-1:0] c, input bit f);
    bit can_push, can_issue;
    bus.in_valid = v;
    bus.in_cmd   = c;
    bus.flush    = f;
    can_push  = v && (mq.size() < DEPTH) && !f;
    can_issue = (!ever_issued || (cyc - last_issue) > GAP) && (mq.size() > 0) && !f;
    @(posedge clk);
    if (can_issue) begin
      m_cmd = mq.pop_front();
      m_sys = 1'b1;
      m_issued = m_issued + 16'd1;
      last_issue = cyc;
      ever_issued = 1'b1;
    end else begin
      m_sys = 1'b0;
    end
    if (f) mq.delete();
    else if (can_push) mq.push_back(c);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_cmd = '0;
    bus.flush = 1'b0;
    model_reset();
    cyc = 0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.syscall !== 1'b0 || bus.command !== '0 || bus.issued_count !== '0 ||
        bus.count !== '0) begin
      errors++;
      $display("[TB] FAIL reset: ready=%b empty=%b full=%b sys=%b cmd=%h iss=%0d cnt=%0d, expected 1 1 0 0 000 0 0",
               bus.in_ready, bus.empty, bus.full, bus.syscall, bus.command, bus.issued_count, bus.count);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.syscall !== 1'b0 || bus.empty !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release: sys=%b empty=%b ready=%b, expected 0 1 1",
               bus.syscall, bus.empty, bus.in_ready);
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    step(1'b1, 12'h123, 1'b0);
    for (int n = 0; n < 12; n++) begin
      step(1'b0, '0, 1'b0);
      if (bus.syscall) pulses++;
      checks++;
      if (bus.syscall !== m_sys || bus.command !== m_cmd) begin
        errors++;
        $display("[TB] FAIL single_issue cyc=%0d: sys=%b cmd=%h, expected %b %h", n, bus.syscall, bus.command, m_sys, m_cmd);
      end
      checks++;
      if (bus.count !== CNT_W'(mq.size()) || bus.issued_count !== m_issued) begin
        errors++;
        $display("[TB] FAIL single_count cyc=%0d: cnt=%0d iss=%0d, expected %0d %0d", n, bus.count, bus.issued_count, mq.size(), m_issued);
      end
      if (n == 0) begin
        checks++;
        if (bus.syscall !== 1'b1) begin
          errors++;
          $display("[TB] FAIL single_latency: sys=%b, expected 1", bus.syscall);
        end
      end
    end
    checks++;
    if (pulses != 1 || bus.command !== 12'h123) begin
      errors++;
      $display("[TB] FAIL single_pulses: pulses=%0d cmd=%h, expected 1 123", pulses, bus.command);
    end
  endtask

  task automatic test_back_to_back();
    logic [CMD_W-1:0] cmds [3];
    int times [$];
    logic [CMD_W-1:0] got [$];
    logic [15:0] base;
    cmds[0] = 12'h201; cmds[1] = 12'h40A; cmds[2] = 12'hE53;
    base = m_issued;
    for (int n = 0; n < 30; n++) begin
      if (n < 3) step(1'b1, cmds[n], 1'b0);
      else step(1'b0, '0, 1'b0);
      if (bus.syscall) begin
        times.push_back(n);
        got.push_back(bus.command);
      end
      checks++;
      if (bus.syscall !== m_sys || bus.command !== m_cmd) begin
        errors++;
        $display("[TB] FAIL b2b_issue cyc=%0d: sys=%b cmd=%h, expected %b %h", n, bus.syscall, bus.command, m_sys, m_cmd);
      end
    end
    checks++;
    if (times.size() != 3 || got.size() != 3) begin
      errors++;
      $display("[TB] FAIL b2b_pulses: pulses=%0d, expected 3", times.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== cmds[i]) begin
          errors++;
          $display("[TB] FAIL b2b_order idx=%0d: cmd=%h, expected %h", i, got[i], cmds[i]);
        end
      end
      checks++;
      if (times[1] - times[0] != GAP + 1 || times[2] - times[1] != GAP + 1) begin
        errors++;
        $display("[TB] FAIL b2b_spacing: gaps=%0d,%0d, expected %0d", times[1] - times[0], times[2] - times[1], GAP + 1);
      end
    end
    checks++;
    if (bus.issued_count - base !== 16'd3) begin
      errors++;
      $display("[TB] FAIL b2b_issued: delta=%0d, expected 3", bus.issued_count - base);
    end
  endtask

  task automatic test_fill();
    int k = 1;
    bit saw_full = 1'b0;
    logic [CMD_W-1:0] got [$];
    for (int n = 0; n < 100; n++) begin
      bit v, ok;
      v  = (k <= 10);
      ok = v && (mq.size() < DEPTH);
      step(v, CMD_W'(k), 1'b0);
      if (ok) k++;
      if (bus.syscall) got.push_back(bus.command);
      if (mq.size() == DEPTH) saw_full = 1'b1;
      checks++;
      if (bus.syscall !== m_sys || bus.command !== m_cmd) begin
        errors++;
        $display("[TB] FAIL fill_issue cyc=%0d: sys=%b cmd=%h, expected %b %h", n, bus.syscall, bus.command, m_sys, m_cmd);
      end
      checks++;
      if (bus.count !== CNT_W'(mq.size()) || bus.full !== (mq.size() == DEPTH) ||
          bus.in_ready !== (mq.size() < DEPTH) || bus.empty !== (mq.size() == 0)) begin
        errors++;
        $display("[TB] FAIL fill_status cyc=%0d: cnt=%0d full=%b ready=%b empty=%b, expected cnt %0d",
                 n, bus.count, bus.full, bus.in_ready, bus.empty, mq.size());
      end
    end
    checks++;
    if (!saw_full || got.size() != 10) begin
      errors++;
      $display("[TB] FAIL fill_total: saw_full=%b issued=%0d, expected 1 10", saw_full, got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got[i] !== CMD_W'(i + 1)) begin
          errors++;
          $display("[TB] FAIL fill_order idx=%0d: cmd=%h, expected %h", i, got[i], CMD_W'(i + 1));
        end
      end
    end
  endtask

  task automatic test_flush();
    int pulses = 0;
    logic [CMD_W-1:0] last;
    for (int n = 0; n < 4; n++) step(1'b1, CMD_W'(12'h500 + n), 1'b0);
    last = m_cmd;
    step(1'b1, 12'hABC, 1'b1);
    checks++;
    if (bus.count !== '0 || bus.empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_clear: cnt=%0d empty=%b, expected 0 1", bus.count, bus.empty);
    end
    for (int n = 0; n < 20; n++) begin
      step(1'b0, '0, 1'b0);
      if (bus.syscall) pulses++;
      checks++;
      if (bus.syscall !== m_sys || bus.command !== m_cmd || bus.count !== CNT_W'(mq.size())) begin
        errors++;
        $display("[TB] FAIL flush_after cyc=%0d: sys=%b cmd=%h cnt=%0d, expected %b %h %0d",
                 n, bus.syscall, bus.command, bus.count, m_sys, m_cmd, mq.size());
      end
    end
    checks++;
    if (pulses != 0 || bus.command !== last) begin
      errors++;
      $display("[TB] FAIL flush_quiet: pulses=%0d cmd=%h, expected 0 %h", pulses, bus.command, last);
    end
  endtask

  task automatic test_reset_mid_hold();
    int pulses = 0;
    for (int n = 0; n < 3; n++) step(1'b1, CMD_W'(12'h700 + n), 1'b0);
    step(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.syscall !== 1'b0 || bus.command !== '0 || bus.issued_count !== '0 ||
        bus.count !== '0 || bus.in_ready !== 1'b1 || bus.empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_reset: sys=%b cmd=%h iss=%0d cnt=%0d ready=%b empty=%b, expected 0 000 0 0 1 1",
               bus.syscall, bus.command, bus.issued_count, bus.count, bus.in_ready, bus.empty);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      step(1'b0, '0, 1'b0);
      if (bus.syscall) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.count !== '0) begin
      errors++;
      $display("[TB] FAIL hold_reset_quiet: pulses=%0d cnt=%0d, expected 0 0", pulses, bus.count);
    end
    step(1'b1, 12'h321, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if (bus.syscall !== 1'b1 || bus.command !== 12'h321 || bus.issued_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL hold_reset_new: sys=%b cmd=%h iss=%0d, expected 1 321 1", bus.syscall, bus.command, bus.issued_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit v, f;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 29) == 0);
      step(v, CMD_W'($urandom), f);
      checks++;
      if (bus.syscall !== m_sys || bus.command !== m_cmd || bus.issued_count !== m_issued) begin
        errors++;
        $display("[TB] FAIL rand_issue cyc=%0d: sys=%b cmd=%h iss=%0d, expected %b %h %0d",
                 n, bus.syscall, bus.command, bus.issued_count, m_sys, m_cmd, m_issued);
      end
      checks++;
      if (bus.count !== CNT_W'(mq.size()) || bus.full !== (mq.size() == DEPTH) ||
          bus.in_ready !== (mq.size() < DEPTH)) begin
        errors++;
        $display("[TB] FAIL rand_status cyc=%0d: cnt=%0d full=%b ready=%b, expected cnt %0d",
                 n, bus.count, bus.full, bus.in_ready, mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_flush();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
